cpu_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute controller for the 8-bit CPU datapath.
- Owns the program counter and ROM fetch.
- Drives GPR read/write addresses, the ALU operation, and stack push/pop strobes from the fetched 24-bit instruction.
- Sits between rom, gpr, alu and stack in top, replacing the purely combinational decoder path with a sequenced one.

---
 rtl/cpu_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute controller for the 8-bit CPU.
// Optional single-step pause state enabled by defining SEQ_SINGLE_STEP_EN.
module cpu_sequencer #(
  parameter int PC_W = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            rom_enable,
  output logic [PC_W-1:0] rom_addr,
  input  logic [23:0]     rom_data,
  output logic            gpr_w_enable,
  output logic [2:0]      gpr_w_addr,
  output logic [7:0]      gpr_w_data,
  output logic [2:0]      gpr_r_addr_a,
  output logic [2:0]      gpr_r_addr_b,
  input  logic [7:0]      gpr_r_data_a,
  input  logic [7:0]      gpr_r_data_b,
  output logic [4:0]      alu_operation,
  output logic [7:0]      alu_A,
  output logic [7:0]      alu_B,
  input  logic [7:0]      alu_C,
  output logic            stack_push_enable,
  output logic [7:0]      stack_push_data,
  output logic            stack_pop_enable,
  input  logic [7:0]      stack_pop_data,
  input  logic            stack_full,
  input  logic            stack_empty,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            fault
);

  localparam logic [4:0] OP_LDI  = 5'h10;
  localparam logic [4:0] OP_JMP  = 5'h11;
  localparam logic [4:0] OP_JZ   = 5'h12;
  localparam logic [4:0] OP_CALL = 5'h13;
  localparam logic [4:0] OP_RET  = 5'h14;
  localparam logic [4:0] OP_PUSH = 5'h15;
  localparam logic [4:0] OP_POP  = 5'h16;
  localparam logic [4:0] OP_HALT = 5'h1F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_POPWB,
    S_HALT,
    S_FAULT
`ifdef SEQ_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

`ifdef SEQ_SINGLE_STEP_EN
  localparam state_t S_AFTER = S_PAUSE;
`else
  localparam state_t S_AFTER = S_FETCH;
`endif

  state_t state;
  logic [23:0] instr;

  logic [4:0] op;
  logic [2:0] rd, ra, rb;
  logic [7:0] imm;
  logic unused_bits;

  assign op  = instr[23:19];
  assign rd  = instr[18:16];
  assign ra  = instr[15:13];
  assign rb  = instr[12:10];
  assign imm = instr[7:0];
  assign unused_bits = ^instr[9:8];

  logic is_alu, is_ldi, is_jmp, is_jz;
  logic is_call, is_ret, is_push, is_pop;
  logic is_halt;

  assign is_alu  = ~op[4];
  assign is_ldi  = op == OP_LDI;
  assign is_jmp  = op == OP_JMP;
  assign is_jz   = op == OP_JZ;
  assign is_call = op == OP_CALL;
  assign is_ret  = op == OP_RET;
  assign is_push = op == OP_PUSH;
  assign is_pop  = op == OP_POP;
  assign is_halt = op == OP_HALT;

  logic [PC_W-1:0] pc_inc, imm_pc, pop_pc;
  logic [7:0] ret_addr;

  assign pc_inc   = pc + PC_W'(1);
  assign imm_pc   = PC_W'(imm);
  assign pop_pc   = PC_W'(stack_pop_data);
  assign ret_addr = 8'(pc_inc);
  assign rom_addr = pc;

  // Strobes and datapath controls decoded from state and latched instruction
  always_comb begin
    rom_enable        = 1'b0;
    gpr_w_enable      = 1'b0;
    gpr_w_addr        = '0;
    gpr_w_data        = '0;
    gpr_r_addr_a      = '0;
    gpr_r_addr_b      = '0;
    alu_operation     = '0;
    alu_A             = '0;
    alu_B             = '0;
    stack_push_enable = 1'b0;
    stack_push_data   = '0;
    stack_pop_enable  = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        state == S_FETCH: rom_enable = 1'b1;
        state == S_EXEC: begin
          gpr_r_addr_a = ra;
          gpr_r_addr_b = rb;
          unique case (1'b1)
            is_alu: begin
              alu_operation = op;
              alu_A         = gpr_r_data_a;
              alu_B         = gpr_r_data_b;
              gpr_w_enable  = 1'b1;
              gpr_w_addr    = rd;
              gpr_w_data    = alu_C;
            end
            is_ldi: begin
              gpr_w_enable = 1'b1;
              gpr_w_addr   = rd;
              gpr_w_data   = imm;
            end
            is_call: begin
              stack_push_enable = !stack_full;
              stack_push_data   = stack_full ? 8'h00 : ret_addr;
            end
            is_push: begin
              stack_push_enable = !stack_full;
              stack_push_data   = stack_full ? 8'h00 : gpr_r_data_a;
            end
            is_ret, is_pop: stack_pop_enable = !stack_empty;
            default: ;
          endcase
        end
        state == S_POPWB: begin
          if (is_pop) begin
            gpr_w_enable = 1'b1;
            gpr_w_addr   = rd;
            gpr_w_data   = stack_pop_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Sequencer state, program counter, instruction and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      instr  <= '0;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      case (state)
        S_IDLE:   if (run) state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          instr <= rom_data;
          state <= S_EXEC;
        end
        S_EXEC: begin
          unique case (1'b1)
            is_jmp: begin
              pc    <= imm_pc;
              state <= S_AFTER;
            end
            is_jz: begin
              pc    <= (gpr_r_data_a == 8'h00) ? imm_pc : pc_inc;
              state <= S_AFTER;
            end
            is_call: begin
              if (stack_full) begin
                state <= S_FAULT;
                fault <= 1'b1;
              end else begin
                pc    <= imm_pc;
                state <= S_AFTER;
              end
            end
            is_ret, is_pop: begin
              if (stack_empty) begin
                state <= S_FAULT;
                fault <= 1'b1;
              end else begin
                state <= S_POPWB;
              end
            end
            is_push: begin
              if (stack_full) begin
                state <= S_FAULT;
                fault <= 1'b1;
              end else begin
                pc    <= pc_inc;
                state <= S_AFTER;
              end
            end
            is_halt: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            default: begin
              pc    <= pc_inc;
              state <= S_AFTER;
            end
          endcase
        end
        S_POPWB: begin
          pc    <= is_ret ? pop_pc : pc_inc;
          state <= S_AFTER;
        end
`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE:  if (step) state <= S_FETCH;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed bench with ROM/GPR/ALU/stack models
// and scoreboards for GPR writes and stack pushes.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif
  logic        rom_enable;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data = '0;
  logic        gpr_w_enable;
  logic [2:0]  gpr_w_addr;
  logic [7:0]  gpr_w_data;
  logic [2:0]  gpr_r_addr_a;
  logic [2:0]  gpr_r_addr_b;
  logic [7:0]  gpr_r_data_a;
  logic [7:0]  gpr_r_data_b;
  logic [4:0]  alu_operation;
  logic [7:0]  alu_A;
  logic [7:0]  alu_B;
  logic [7:0]  alu_C;
  logic        stack_push_enable;
  logic [7:0]  stack_push_data;
  logic        stack_pop_enable;
  logic [7:0]  stack_pop_data = '0;
  logic        stack_full;
  logic        stack_empty;
  logic [7:0]  pc;
  logic        halted;
  logic        fault;

  cpu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .rom_enable(rom_enable),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .gpr_w_enable(gpr_w_enable),
    .gpr_w_addr(gpr_w_addr),
    .gpr_w_data(gpr_w_data),
    .gpr_r_addr_a(gpr_r_addr_a),
    .gpr_r_addr_b(gpr_r_addr_b),
    .gpr_r_data_a(gpr_r_data_a),
    .gpr_r_data_b(gpr_r_data_b),
    .alu_operation(alu_operation),
    .alu_A(alu_A),
    .alu_B(alu_B),
    .alu_C(alu_C),
    .stack_push_enable(stack_push_enable),
    .stack_push_data(stack_push_data),
    .stack_pop_enable(stack_pop_enable),
    .stack_pop_data(stack_pop_data),
    .stack_full(stack_full),
    .stack_empty(stack_empty),
    .pc(pc),
    .halted(halted),
    .fault(fault)
  );

  always #5 clk = ~clk;

  logic [23:0] rom [256];
  logic [7:0]  gpr [8];
  logic [7:0]  stk [4];
  int          sp = 0;

  always @(posedge clk)
    if (rom_enable) rom_data <= rom[rom_addr];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) gpr[i] <= 8'h00;
    end else if (gpr_w_enable) begin
      gpr[gpr_w_addr] <= gpr_w_data;
    end
  end

  assign gpr_r_data_a = gpr[gpr_r_addr_a];
  assign gpr_r_data_b = gpr[gpr_r_addr_b];

  assign alu_C = (alu_operation == 5'h01) ?
                 alu_A + alu_B : alu_A ^ alu_B;

  always @(posedge clk) begin
    if (rst) begin
      sp <= 0;
    end else if (stack_push_enable) begin
      stk[sp] <= stack_push_data;
      sp      <= sp + 1;
    end else if (stack_pop_enable) begin
      stack_pop_data <= stk[sp-1];
      sp             <= sp - 1;
    end
  end

  assign stack_full  = (sp == 4);
  assign stack_empty = (sp == 0);

  int n_assert = 0;
  int n_fail   = 0;
  int pops_seen = 0;
  logic [10:0] wq [$];
  logic [7:0]  pq [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: GPR writes and pushes against queued expectations
  always @(negedge clk) begin
    if (gpr_w_enable === 1'b1) begin
      chk("gpr_w_expected", 32'(wq.size() != 0), 1);
      if (wq.size() != 0)
        chk("gpr_w", {gpr_w_addr, gpr_w_data}, wq.pop_front());
    end
    if (stack_push_enable === 1'b1) begin
      chk("push_expected", 32'(pq.size() != 0), 1);
      if (pq.size() != 0)
        chk("push_data", stack_push_data, pq.pop_front());
    end
    if (stack_pop_enable === 1'b1) pops_seen++;
    if (stack_push_enable === 1'b1 || stack_pop_enable === 1'b1)
      chk("push_pop_excl",
          stack_push_enable & stack_pop_enable, 0);
  end

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 24'hF80000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_pc(input logic [7:0] t, input int budget,
                         input string tag);
    int n = 0;
    while (pc !== t && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, pc, t);
  endtask

  task automatic wait_halt(input int budget, input string tag);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, halted, 1);
  endtask

  task automatic wait_fault(input int budget, input string tag);
    int n = 0;
    while (fault !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, fault, 1);
  endtask

  task automatic wait_wen(input logic [2:0] a, input int budget,
                          input string tag);
    int n = 0;
    while (!(gpr_w_enable === 1'b1 && gpr_w_addr === a) &&
           n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, gpr_w_enable, 1);
  endtask

  task automatic wait_push(input int budget, input string tag);
    int n = 0;
    while (stack_push_enable !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, stack_push_enable, 1);
  endtask

  task automatic wait_pop(input int budget, input string tag);
    int n = 0;
    while (stack_pop_enable !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, stack_pop_enable, 1);
  endtask

  initial begin
    rom_clear();
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_pc", pc, 8'h00);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_strobes",
        {rom_enable, gpr_w_enable, stack_push_enable,
         stack_pop_enable}, 0);
    chk("rst_aluop", alu_operation, 0);

    // LDI r1,5 then HALT
    rom[0] = 24'h810005;
    rom[1] = 24'hF80000;
    wq.push_back({3'd1, 8'h05});
    rst = 1'b0;
    start();
    chk("fetch_rom_en", rom_enable, 1);
    chk("fetch_rom_addr", rom_addr, 8'h00);
    @(negedge clk);
    chk("decode_no_wen", gpr_w_enable, 0);
    @(negedge clk);
    chk("ldi_wen_cycle3", gpr_w_enable, 1);
    chk("ldi_waddr", gpr_w_addr, 3'd1);
    chk("ldi_wdata", gpr_w_data, 8'h05);
    wait_halt(20, "ldi_halt");
    chk("ldi_halt_pc", pc, 8'h01);
    @(negedge clk);
    chk("halt_no_rom", rom_enable, 0);

    // ALU add r3 = r1 + r2
    do_reset();
    rom_clear();
    rom[0] = 24'h810005;
    rom[1] = 24'h820003;
    rom[2] = 24'hB80000;
    rom[3] = 24'hB80000;
    rom[4] = 24'h0B2800;
    wq.push_back({3'd1, 8'h05});
    wq.push_back({3'd2, 8'h03});
    wq.push_back({3'd3, 8'h08});
    start();
    wait_wen(3'd3, 40, "alu_wen");
    chk("alu_op", alu_operation, 5'h01);
    chk("alu_a", alu_A, 8'h05);
    chk("alu_b", alu_B, 8'h03);
    chk("alu_wdata", gpr_w_data, 8'h08);
    chk("alu_pc", pc, 8'h04);
    wait_halt(20, "alu_halt");
    chk("alu_halt_pc", pc, 8'h05);

    // CALL 0x20 at pc 4, RET back to 5
    do_reset();
    rom_clear();
    for (int i = 0; i < 4; i++) rom[i] = 24'hB80000;
    rom[4]    = 24'h980020;
    rom[8'h20] = 24'hA00000;
    pq.push_back(8'h05);
    start();
    wait_push(40, "call_push");
    chk("call_pc", pc, 8'h04);
    @(negedge clk);
    chk("push_pulse", stack_push_enable, 0);
    chk("call_target", pc, 8'h20);
    wait_pop(10, "ret_pop");
    chk("ret_pc_exec", pc, 8'h20);
    @(negedge clk);
    chk("pop_pulse", stack_pop_enable, 0);
    @(negedge clk);
    chk("ret_pc", pc, 8'h05);
    wait_halt(20, "ret_halt");
    chk("ret_halt_pc", pc, 8'h05);

    // JZ taken / not taken, JMP 0xFF then wrap to 0
    do_reset();
    rom_clear();
    rom[8'h00] = 24'h900010;
    rom[8'h10] = 24'h800001;
    rom[8'h11] = 24'h900030;
    rom[8'h12] = 24'h8800FF;
    rom[8'hFF] = 24'hB80000;
    wq.push_back({3'd0, 8'h01});
    start();
    wait_pc(8'h10, 10, "jz_taken");
    wait_pc(8'h11, 10, "ldi_r0");
    wait_pc(8'h12, 10, "jz_not_taken");
    wait_pc(8'hFF, 10, "jmp_ff");
    wait_pc(8'h00, 10, "pc_wrap");
    wait_pc(8'h01, 10, "jz_after_wrap");
    wait_halt(20, "jz_halt");
    chk("jz_halt_pc", pc, 8'h01);

    // RET on empty stack faults
    do_reset();
    rom_clear();
    rom[0] = 24'hA00000;
    pops_seen = 0;
    start();
    wait_fault(20, "ret_fault");
    chk("fault_no_pop", pops_seen, 0);
    chk("fault_pc", pc, 8'h00);
    repeat (5) @(negedge clk);
    chk("fault_sticky", fault, 1);
    chk("fault_not_halt", halted, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("fault_clr", fault, 0);
    chk("fault_rst_pc", pc, 8'h00);
    rst = 1'b0;

    // Reset during DECODE aborts the LDI
    do_reset();
    rom_clear();
    rom[0] = 24'h850077;
    start();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_strobes",
        {rom_enable, gpr_w_enable, stack_push_enable,
         stack_pop_enable}, 0);
    chk("midrst_pc", pc, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_idle", {rom_enable, gpr_w_enable}, 0);

`ifdef SEQ_SINGLE_STEP_EN
    // Single step: waits in PAUSE until step pulse
    do_reset();
    rom_clear();
    rom[0] = 24'h810005;
    wq.push_back({3'd1, 8'h05});
    start();
    repeat (10) @(negedge clk);
    chk("pause_pc", pc, 8'h01);
    chk("pause_not_halt", halted, 0);
    chk("pause_no_rom", rom_enable, 0);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_halt(20, "step_halt");
    chk("step_halt_pc", pc, 8'h01);
`endif

    chk("wq_drained", wq.size(), 0);
    chk("pq_drained", pq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
